// File: rtl/spi_arbiter_ctrl_if.sv
// Request/grant and SPI pin bundle shared between two requesters, the arbiter and the SPI device.
// The slave modport is the arbiter's view; master is the requester/device side.
interface spi_arbiter_ctrl_if;
    logic       req0;
    logic       req1;
    logic       wr0;
    logic       wr1;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] rx_data;
    logic       CS;
    logic       S_clk;
    logic       MOSI;
    logic       MISO;
    logic [3:0] counter;

    modport slave (
        input  req0, req1, wr0, wr1, tx0, tx1, MISO,
        output gnt0, gnt1, busy, done, done_id, rx_data, CS, S_clk, MOSI, counter
    );

    modport master (
        output req0, req1, wr0, wr1, tx0, tx1, MISO,
        input  gnt0, gnt1, busy, done, done_id, rx_data, CS, S_clk, MOSI, counter
    );
endinterface

// File: rtl/spi_arbiter_ctrl.sv
// Round-robin arbiter for two clients sharing one SPI master link; each grant runs
// one 8-bit mode-0 frame (MSB first) and reports the MISO byte with a done pulse.
module spi_arbiter_ctrl #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_arbiter_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    state_t     state;
    logic [3:0] div_cnt;
    logic       last;
    logic       winner;
    logic       wr_lat;
    logic [6:0] tx_sh;
    logic [7:0] rx_sh;
    logic       pick0;

    // Requester 0 wins when it is alone, or on a tie when requester 1 was served last.
    assign pick0 = bus.req0 & (~bus.req1 | last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            last        <= 1'b1;
            winner      <= 1'b0;
            wr_lat      <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.rx_data <= '0;
            bus.CS      <= 1'b1;
            bus.S_clk   <= 1'b0;
            bus.MOSI    <= 1'b0;
            bus.counter <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        winner      <= ~pick0;
                        last        <= ~pick0;
                        bus.gnt0    <= pick0;
                        bus.gnt1    <= ~pick0;
                        bus.busy    <= 1'b1;
                        bus.CS      <= 1'b0;
                        bus.S_clk   <= 1'b0;
                        bus.counter <= '0;
                        div_cnt     <= '0;
                        rx_sh       <= '0;
                        wr_lat      <= pick0 ? bus.wr0 : bus.wr1;
                        tx_sh       <= pick0 ? bus.tx0[6:0] : bus.tx1[6:0];
                        bus.MOSI    <= pick0 ? (bus.wr0 & bus.tx0[7]) : (bus.wr1 & bus.tx1[7]);
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end

                // Low half-period first, then alternate; the eighth high phase ends the shift.
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!bus.S_clk) begin
                            bus.S_clk <= 1'b1;
                            rx_sh     <= {rx_sh[6:0], bus.MISO};
                            if (bus.counter != 4'd8) begin
                                bus.counter <= bus.counter + 4'd1;
                            end
                        end else begin
                            bus.S_clk <= 1'b0;
                            if (bus.counter == 4'd8) begin
                                state <= HOLD;
                            end else begin
                                bus.MOSI <= wr_lat & tx_sh[6];
                                tx_sh    <= {tx_sh[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end

                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bus.CS  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end

                // First cycle after CS rises publishes the result; the next one releases the grant.
                DONE: begin
                    if (!bus.done) begin
                        bus.done    <= 1'b1;
                        bus.done_id <= winner;
                        bus.rx_data <= rx_sh;
                    end else begin
                        bus.gnt0    <= 1'b0;
                        bus.gnt1    <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.counter <= '0;
                        bus.MOSI    <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter_ctrl.sv
// Directed bench for spi_arbiter_ctrl: table of single frames plus hand sequences for
// round-robin, mid-frame reset, request withdrawal and CLK_DIV=1 timing.
module tb_spi_arbiter_ctrl;

    typedef struct {
        logic       req0;
        logic       req1;
        logic       wr0;
        logic       wr1;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic       lb;
        logic [7:0] miso;
        logic       exp_id;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loopback = 1'b1;
    logic miso_bit = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    spi_arbiter_ctrl_if bus ();
    spi_arbiter_ctrl_if bus1 ();

    assign bus.MISO  = loopback ? bus.MOSI : miso_bit;
    assign bus1.MISO = bus1.MOSI;

    spi_arbiter_ctrl #(.CLK_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    spi_arbiter_ctrl #(.CLK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        loopback = v.lb;
        bus.wr0  = v.wr0;
        bus.wr1  = v.wr1;
        bus.tx0  = v.tx0;
        bus.tx1  = v.tx1;
        bus.req0 = v.req0;
        bus.req1 = v.req1;
    endtask

    // Follows one frame on the CLK_DIV=2 instance, sampling 1 time unit after each rising clk.
    task automatic watch_frame(input logic drive_miso, input logic [7:0] miso_byte,
                               output int gwait, output int lat, output int cs_low,
                               output int rises, output logic [7:0] mosi_seen,
                               output logic mosi_any, output logic gid, output logic did,
                               output logic [7:0] rx, output logic [3:0] cnt,
                               output logic both, output logic ok);
        int   idx;
        logic prev;
        ok = 1'b0; gwait = 0; lat = 0; cs_low = 0; rises = 0; mosi_seen = '0;
        mosi_any = 1'b0; gid = 1'b0; did = 1'b0; rx = '0; cnt = '0; both = 1'b0;
        idx = 6;
        if (drive_miso) miso_bit = miso_byte[7];
        while (!(bus.gnt0 || bus.gnt1) && gwait < 40) begin
            @(posedge clk); #1;
            gwait++;
        end
        if (!(bus.gnt0 || bus.gnt1)) return;
        gid  = bus.gnt1;
        both = bus.gnt0 & bus.gnt1;
        prev = bus.S_clk;
        if (!bus.CS) begin
            cs_low   = 1;
            mosi_any = bus.MOSI;
        end
        while (!ok && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            both = both | (bus.gnt0 & bus.gnt1);
            if (!bus.CS) begin
                cs_low++;
                mosi_any = mosi_any | bus.MOSI;
            end
            if (bus.S_clk && !prev) begin
                rises++;
                mosi_seen = {mosi_seen[6:0], bus.MOSI};
            end
            if (!bus.S_clk && prev && drive_miso && idx >= 0) begin
                miso_bit = miso_byte[idx];
                idx--;
            end
            prev = bus.S_clk;
            if (bus.done) begin
                ok  = 1'b1;
                did = bus.done_id;
                rx  = bus.rx_data;
                cnt = bus.counter;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         gwait, lat, cs_low, rises, t, r1, r2;
        logic [7:0] mosi_seen, rx;
        logic [3:0] cnt;
        logic       mosi_any, gid, did, both, ok, seen;
        logic [1:0] exp_order;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h00, 1'b1, 8'h00, 1'b0, 8'hF0, 8'hF0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'hA5, 1'b1, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h81, 1'b0, 8'h81, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h96, 1'b1, 8'h00, 1'b1, 8'h96, 8'h96};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h3C};

        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
        bus.tx0 = '0; bus.tx1 = '0;
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.wr0 = 1'b0; bus1.wr1 = 1'b0;
        bus1.tx0 = '0; bus1.tx1 = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check_output("rst_busy",    bus.busy, 0);
        check_output("rst_done",    {bus.done, bus.done_id}, 0);
        check_output("rst_rx",      bus.rx_data, 32'h00);
        check_output("rst_cs",      bus.CS, 1);
        check_output("rst_sclk",    {bus.S_clk, bus.MOSI}, 0);
        check_output("rst_counter", bus.counter, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            watch_frame(~vecs[i].lb, vecs[i].miso, gwait, lat, cs_low, rises, mosi_seen,
                        mosi_any, gid, did, rx, cnt, both, ok);
            check_output($sformatf("v%0d_done_seen", i), ok, 1);
            check_output($sformatf("v%0d_gnt_id", i), gid, vecs[i].exp_id);
            check_output($sformatf("v%0d_done_id", i), did, vecs[i].exp_id);
            check_output($sformatf("v%0d_rx", i), rx, vecs[i].exp_rx);
            check_output($sformatf("v%0d_mosi_bits", i), mosi_seen, vecs[i].exp_mosi);
            check_output($sformatf("v%0d_mosi_any", i), mosi_any, |vecs[i].exp_mosi);
            check_output($sformatf("v%0d_latency", i), lat, 37);
            check_output($sformatf("v%0d_cs_low", i), cs_low, 36);
            check_output($sformatf("v%0d_rises", i), rises, 8);
            check_output($sformatf("v%0d_counter", i), cnt, 8);
            check_output($sformatf("v%0d_onehot", i), both, 0);
            @(posedge clk); #1;
            check_output($sformatf("v%0d_after_done", i), bus.done, 0);
            check_output($sformatf("v%0d_after_busy", i), bus.busy, 0);
            check_output($sformatf("v%0d_after_gnt", i), {30'd0, bus.gnt1, bus.gnt0}, 0);
            check_output($sformatf("v%0d_after_cnt", i), bus.counter, 0);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end

        // Reset asserted in the middle of the shift phase.
        loopback = 1'b1; bus.wr0 = 1'b1; bus.tx0 = 8'hAA; bus.req0 = 1'b1;
        t = 0;
        while (bus.counter != 4'd4 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("rstmid_reach_cnt4", bus.counter, 4);
        #2 reset = 1'b0;
        #1;
        check_output("rstmid_cs",      bus.CS, 1);
        check_output("rstmid_sclk",    bus.S_clk, 0);
        check_output("rstmid_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 0);
        check_output("rstmid_busy",    bus.busy, 0);
        check_output("rstmid_counter", bus.counter, 0);
        check_output("rstmid_rx",      bus.rx_data, 32'h00);
        seen = bus.done;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | bus.done;
        end
        check_output("rstmid_no_done", seen, 0);
        @(negedge clk) reset = 1'b1;
        watch_frame(1'b0, 8'h00, gwait, lat, cs_low, rises, mosi_seen,
                    mosi_any, gid, did, rx, cnt, both, ok);
        check_output("rstmid_fresh_done", ok, 1);
        check_output("rstmid_fresh_id",   {did, gid}, 0);
        check_output("rstmid_fresh_rx",   rx, 32'hAA);
        check_output("rstmid_fresh_lat",  lat, 37);
        @(posedge clk); #1;
        bus.req0 = 1'b0;

        // Fresh reset so the tie-break starts with requester 0, then hold both requests.
        #2 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        bus.wr0 = 1'b1; bus.wr1 = 1'b1; bus.tx0 = 8'h3C; bus.tx1 = 8'hC3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_order = k[0] ? 2'b10 : 2'b01;
            watch_frame(1'b0, 8'h00, gwait, lat, cs_low, rises, mosi_seen,
                        mosi_any, gid, did, rx, cnt, both, ok);
            check_output($sformatf("rr%0d_done_seen", k), ok, 1);
            check_output($sformatf("rr%0d_gnt", k), gid, exp_order[1]);
            check_output($sformatf("rr%0d_done_id", k), did, exp_order[1]);
            check_output($sformatf("rr%0d_rx", k), rx, exp_order[1] ? 32'hC3 : 32'h3C);
            check_output($sformatf("rr%0d_onehot", k), both, 0);
            if (k > 0) check_output($sformatf("rr%0d_gap", k), gwait, 1);
            @(posedge clk); #1;
            check_output($sformatf("rr%0d_idle_gap", k), bus.busy, 0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Requester 0 withdraws and changes its inputs partway through its frame.
        repeat (2) @(posedge clk);
        #1;
        bus.wr0 = 1'b1; bus.tx0 = 8'h69; bus.req0 = 1'b1;
        t = 0;
        while (bus.counter != 4'd3 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("wd_reach_cnt3", bus.counter, 3);
        bus.req0 = 1'b0; bus.tx0 = 8'h00; bus.wr0 = 1'b0;
        t = 0;
        while (!bus.done && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("wd_done_seen", bus.done, 1);
        check_output("wd_done_id",   bus.done_id, 0);
        check_output("wd_rx",        bus.rx_data, 32'h69);
        repeat (3) @(posedge clk);
        #1;
        check_output("wd_no_regrant", {bus.busy, bus.gnt1, bus.gnt0}, 0);

        // CLK_DIV=1 instance: single request timing.
        bus1.wr0 = 1'b1; bus1.tx0 = 8'hC5; bus1.req0 = 1'b1;
        t = 0;
        while (!bus1.gnt0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("d1_grant", bus1.gnt0, 1);
        lat = 0; cs_low = bus1.CS ? 0 : 1; rises = 0; r1 = -1; r2 = -1;
        seen = bus1.S_clk; ok = 1'b0; rx = '0; did = 1'b1;
        while (!ok && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!bus1.CS) cs_low++;
            if (bus1.S_clk && !seen) begin
                rises++;
                if (rises == 1) r1 = lat;
                if (rises == 2) r2 = lat;
            end
            seen = bus1.S_clk;
            if (bus1.done) begin
                ok  = 1'b1;
                rx  = bus1.rx_data;
                did = bus1.done_id;
            end
        end
        bus1.req0 = 1'b0;
        check_output("d1_done_seen", ok, 1);
        check_output("d1_latency",   lat, 19);
        check_output("d1_cs_low",    cs_low, 18);
        check_output("d1_rises",     rises, 8);
        check_output("d1_period",    r2 - r1, 2);
        check_output("d1_rx",        rx, 32'hC5);
        check_output("d1_done_id",   did, 0);
        @(posedge clk); #1;
        check_output("d1_done_width", bus1.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
